// File: rtl/ddram_wr_pkg.sv
// ddram_wr_pkg: shared entry type and byte-merge helper for the DDRAM write coalescer
package ddram_wr_pkg;
  localparam int DROP_CNT_W = 16;
  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_entry_t;
  function automatic logic [63:0] merge_be_data(input logic [63:0] old_data, input logic [63:0] new_data, input logic [7:0] be);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ddram_wr_fifo.sv
// ddram_wr_fifo: synchronous FIFO of write entries; a pop while full frees room for a same-cycle push
module ddram_wr_fifo
  import ddram_wr_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  wr_entry_t           wr_data,
  input  logic                rd_en,
  output wr_entry_t           rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  wr_entry_t mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty   = count == '0;
  assign full    = count == (DEPTH_LOG2 + 1)'(DEPTH);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  // storage array; contents are don't-care until pointed at
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      count  <= count + (DEPTH_LOG2 + 1)'(do_wr) - (DEPTH_LOG2 + 1)'(do_rd);
    end
  end
endmodule

// File: rtl/ddram_write_coalescer.sv
// ddram_write_coalescer: stages and merges same-word pixel writes, queues them, and drives DDRAM write beats
module ddram_write_coalescer
  import ddram_wr_pkg::*;
#(
  parameter int DEPTH_LOG2    = 6,
  parameter int COALESCE      = 1,
  parameter int FLUSH_TIMEOUT = 15
) (
  input  logic                  CLK_VIDEO,
  input  logic                  RESET,
  input  logic [28:0]           IN_ADDR,
  input  logic [63:0]           IN_DIN,
  input  logic [7:0]            IN_BE,
  input  logic                  IN_WE,
  input  logic                  FLUSH,
  output logic                  PENDING,
  output logic                  OVERFLOW,
  output logic [DROP_CNT_W-1:0] DROP_CNT,
  output logic                  DDRAM_CLK,
  input  logic                  DDRAM_BUSY,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic [28:0]           DDRAM_ADDR,
  output logic [63:0]           DDRAM_DIN,
  output logic [7:0]            DDRAM_BE,
  output logic                  DDRAM_WE,
  output logic                  DDRAM_RD
);
  wr_entry_t stage, fifo_out;
  logic stage_valid, merge, timeout, push, pop, drop;
  logic fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  logic [7:0] idle_cnt;
  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign merge   = IN_WE && stage_valid && COALESCE != 0 && !FLUSH && IN_ADDR == stage.addr;
  assign timeout = idle_cnt == 8'(FLUSH_TIMEOUT - 1);
  assign push    = stage_valid && (IN_WE ? !merge : (FLUSH || timeout || COALESCE == 0));
  assign pop     = (!DDRAM_WE || !DDRAM_BUSY) && !fifo_empty;
  assign drop    = push && fifo_full && !pop;
  assign PENDING = stage_valid || fifo_count != '0 || DDRAM_WE;
  ddram_wr_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(CLK_VIDEO),
    .rst(RESET),
    .wr_en(push),
    .wr_data(stage),
    .rd_en(pop),
    .rd_data(fifo_out),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // staging entry: merge same-word writes, otherwise push the old entry and load the new one
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      stage       <= '0;
      stage_valid <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      idle_cnt <= IN_WE ? '0 : idle_cnt + {7'd0, idle_cnt != 8'hFF};
      if (merge) begin
        stage.data <= merge_be_data(stage.data, IN_DIN, IN_BE);
        stage.be   <= stage.be | IN_BE;
      end else if (IN_WE) begin
        stage <= '{IN_ADDR, IN_DIN, IN_BE};
      end
      stage_valid <= IN_WE || (stage_valid && !push);
    end
  end
  // output beat register: holds while the slave stalls, reloads from the FIFO otherwise
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
    end else if (!DDRAM_WE || !DDRAM_BUSY) begin
      DDRAM_WE <= !fifo_empty;
      if (!fifo_empty) {DDRAM_ADDR, DDRAM_DIN, DDRAM_BE} <= fifo_out;
    end
  end
  // sticky overflow flag and saturating drop counter
  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      DROP_CNT <= DROP_CNT != '1 ? DROP_CNT + DROP_CNT_W'(1) : DROP_CNT;
    end
  end
endmodule

// File: tb/tb_ddram_write_coalescer.sv
// tb_ddram_write_coalescer: scenario tasks plus a randomized run against a transaction-level model
module tb_ddram_write_coalescer;
  logic CLK_VIDEO = 0, RESET = 1, IN_WE = 0, FLUSH = 0, DDRAM_BUSY = 0;
  logic [28:0] IN_ADDR = '0;
  logic [63:0] IN_DIN = '0;
  logic [7:0]  IN_BE = '0;
  int checks = 0, failures = 0;
  logic        c_pend, c_ovf, c_clk, c_we, c_rd, p_pend, p_ovf, p_clk, p_we, p_rd, s_pend, s_ovf, s_clk, s_we, s_rd;
  logic [15:0] c_drop, p_drop, s_drop;
  logic [7:0]  c_bc, p_bc, s_bc, c_be, p_be, s_be;
  logic [28:0] c_addr, p_addr, s_addr;
  logic [63:0] c_din, p_din, s_din;
  bit          model_on = 0;
  bit          m_valid;
  logic [28:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  int          m_idle;
  logic [100:0] exp_q[$];

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  ddram_write_coalescer #(.DEPTH_LOG2(6), .COALESCE(1), .FLUSH_TIMEOUT(15)) u_c (
    .CLK_VIDEO(CLK_VIDEO), .RESET(RESET), .IN_ADDR(IN_ADDR), .IN_DIN(IN_DIN), .IN_BE(IN_BE), .IN_WE(IN_WE),
    .FLUSH(FLUSH), .PENDING(c_pend), .OVERFLOW(c_ovf), .DROP_CNT(c_drop), .DDRAM_CLK(c_clk), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(c_bc), .DDRAM_ADDR(c_addr), .DDRAM_DIN(c_din), .DDRAM_BE(c_be), .DDRAM_WE(c_we), .DDRAM_RD(c_rd));
  ddram_write_coalescer #(.DEPTH_LOG2(6), .COALESCE(0), .FLUSH_TIMEOUT(15)) u_p (
    .CLK_VIDEO(CLK_VIDEO), .RESET(RESET), .IN_ADDR(IN_ADDR), .IN_DIN(IN_DIN), .IN_BE(IN_BE), .IN_WE(IN_WE),
    .FLUSH(FLUSH), .PENDING(p_pend), .OVERFLOW(p_ovf), .DROP_CNT(p_drop), .DDRAM_CLK(p_clk), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(p_bc), .DDRAM_ADDR(p_addr), .DDRAM_DIN(p_din), .DDRAM_BE(p_be), .DDRAM_WE(p_we), .DDRAM_RD(p_rd));
  ddram_write_coalescer #(.DEPTH_LOG2(2), .COALESCE(1), .FLUSH_TIMEOUT(15)) u_s (
    .CLK_VIDEO(CLK_VIDEO), .RESET(RESET), .IN_ADDR(IN_ADDR), .IN_DIN(IN_DIN), .IN_BE(IN_BE), .IN_WE(IN_WE),
    .FLUSH(FLUSH), .PENDING(s_pend), .OVERFLOW(s_ovf), .DROP_CNT(s_drop), .DDRAM_CLK(s_clk), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(s_bc), .DDRAM_ADDR(s_addr), .DDRAM_DIN(s_din), .DDRAM_BE(s_be), .DDRAM_WE(s_we), .DDRAM_RD(s_rd));

  // transaction-level view of the staging rules for the COALESCE=1, timeout 15 instance
  task automatic model_step();
    if (IN_WE) begin
      if (m_valid && IN_ADDR == m_addr && !FLUSH) begin
        for (int i = 0; i < 8; i++) if (IN_BE[i]) m_data[i*8 +: 8] = IN_DIN[i*8 +: 8];
        m_be = m_be | IN_BE;
      end else begin
        if (m_valid) exp_q.push_back({m_addr, m_data, m_be});
        m_addr = IN_ADDR; m_data = IN_DIN; m_be = IN_BE; m_valid = 1;
      end
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_valid && (FLUSH || m_idle == 15)) begin
        exp_q.push_back({m_addr, m_data, m_be});
        m_valid = 0;
      end
    end
  endtask

  task automatic cyc(input logic we, input logic [28:0] a, input logic [63:0] d, input logic [7:0] be, input logic fl, input logic busy);
    IN_WE = we; IN_ADDR = a; IN_DIN = d; IN_BE = be; FLUSH = fl; DDRAM_BUSY = busy;
    @(posedge CLK_VIDEO);
    if (model_on) model_step();
    #1;
  endtask

  task automatic idle(input logic busy);
    cyc(0, '0, '0, '0, 0, busy);
  endtask

  task automatic do_reset();
    RESET = 1; idle(0); idle(0); RESET = 0;
    m_valid = 0; m_idle = 0; exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (c_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", c_we); end
    checks++; if ({c_addr, c_din, c_be} !== 101'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", {c_addr, c_din, c_be}); end
    checks++; if ({c_ovf, c_drop} !== 17'd0) begin failures++; $display("FAIL reset_ovf_drop got=%h exp=0", {c_ovf, c_drop}); end
    checks++; if (c_pend !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", c_pend); end
    checks++; if ({c_bc, c_rd} !== {8'd1, 1'b0}) begin failures++; $display("FAIL reset_consts got=%h exp=%h", {c_bc, c_rd}, {8'd1, 1'b0}); end
    checks++; if ({p_we, s_we, p_pend, s_pend} !== 4'd0) begin failures++; $display("FAIL reset_others got=%b exp=0000", {p_we, s_we, p_pend, s_pend}); end
    checks++; if (c_clk !== CLK_VIDEO) begin failures++; $display("FAIL ddram_clk got=%b exp=%b", c_clk, CLK_VIDEO); end
  endtask

  task automatic test_merge();
    int nb = 0;
    logic [100:0] beat = '0;
    do_reset();
    cyc(1, 29'h100, {32'hAABBCCDD, $urandom}, 8'hF0, 0, 0);
    cyc(1, 29'h100, {$urandom, 32'h11223344}, 8'h0F, 0, 0);
    cyc(0, '0, '0, '0, 1, 0);
    for (int k = 0; k < 12; k++) begin
      if (c_we) begin nb++; beat = {c_addr, c_din, c_be}; end
      idle(0);
    end
    checks++; if (nb !== 1) begin failures++; $display("FAIL merge_count got=%0d exp=1", nb); end
    checks++; if (beat !== {29'h100, 64'hAABBCCDD11223344, 8'hFF}) begin failures++; $display("FAIL merge_beat got=%h exp=%h", beat, {29'h100, 64'hAABBCCDD11223344, 8'hFF}); end
  endtask

  task automatic test_latency();
    logic [63:0] d = {$urandom, $urandom};
    do_reset();
    cyc(1, 29'h55, d, 8'hFF, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      checks++; if (p_we !== (k == 3)) begin failures++; $display("FAIL latency_we cycle=%0d got=%b exp=%b", k, p_we, k == 3); end
      checks++; if (p_pend !== (k <= 3)) begin failures++; $display("FAIL latency_pending cycle=%0d got=%b exp=%b", k, p_pend, k <= 3); end
      if (k == 3) begin
        checks++; if ({p_addr, p_din} !== {29'h55, d}) begin failures++; $display("FAIL latency_beat got=%h exp=%h", {p_addr, p_din}, {29'h55, d}); end
      end
      idle(0);
    end
  endtask

  task automatic test_stall();
    logic [63:0] data [10];
    int nb = 0;
    do_reset();
    for (int i = 0; i < 10; i++) data[i] = {$urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      if (i < 10) cyc(1, 29'(i), data[i], 8'hFF, 0, 1);
      else idle(1);
      if (i >= 2) begin
        checks++; if ({c_we, c_addr, c_din, c_be} !== {1'b1, 29'd0, data[0], 8'hFF}) begin failures++; $display("FAIL stall_hold cycle=%0d got=%h exp=%h", i + 1, {c_we, c_addr, c_din, c_be}, {1'b1, 29'd0, data[0], 8'hFF}); end
      end
    end
    for (int j = 0; j < 15; j++) begin
      if (c_we) begin
        checks++; if ({c_addr, c_din} !== {29'(nb), data[nb % 10]} || j !== nb) begin failures++; $display("FAIL stall_order cycle=%0d got=%h exp=%h beat=%0d", j, {c_addr, c_din}, {29'(nb), data[nb % 10]}, nb); end
        nb++;
      end
      cyc(0, '0, '0, '0, j == 0, 0);
    end
    checks++; if (nb !== 10) begin failures++; $display("FAIL stall_count got=%0d exp=10", nb); end
    checks++; if (c_ovf !== 1'b0) begin failures++; $display("FAIL stall_ovf got=%b exp=0", c_ovf); end
  endtask

  task automatic test_overflow();
    logic [28:0] exp_a [6] = '{29'd0, 29'd1, 29'd2, 29'd3, 29'd4, 29'd9};
    int nb = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 29'(i), {$urandom, $urandom}, 8'hFF, 0, 1);
    for (int i = 0; i < 3; i++) idle(1);
    checks++; if (s_drop !== 16'd4) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=4", s_drop); end
    checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", s_ovf); end
    checks++; if ({s_we, s_addr, s_pend} !== {1'b1, 29'd0, 1'b1}) begin failures++; $display("FAIL ovf_hold got=%h exp=%h", {s_we, s_addr, s_pend}, {1'b1, 29'd0, 1'b1}); end
    for (int j = 0; j < 20; j++) begin
      if (s_we) begin
        checks++; if (nb > 5 || s_addr !== exp_a[nb % 6]) begin failures++; $display("FAIL ovf_order beat=%0d got=%h exp=%h", nb, s_addr, exp_a[nb % 6]); end
        nb++;
      end
      cyc(0, '0, '0, '0, j == 0, 0);
    end
    checks++; if (nb !== 6) begin failures++; $display("FAIL ovf_beats got=%0d exp=6", nb); end
    checks++; if ({s_ovf, s_drop} !== {1'b1, 16'd4}) begin failures++; $display("FAIL ovf_sticky got=%h exp=%h", {s_ovf, s_drop}, {1'b1, 16'd4}); end
  endtask

  task automatic test_timeout();
    logic [63:0] d1 = {$urandom, $urandom}, d2 = {$urandom, $urandom};
    do_reset();
    cyc(1, 29'h77, d1, 8'h0F, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      checks++; if (c_we !== 1'b0) begin failures++; $display("FAIL timeout_early cycle=%0d got=%b exp=0", k, c_we); end
      idle(0);
    end
    checks++; if ({c_we, c_addr, c_din, c_be} !== {1'b1, 29'h77, d1, 8'h0F}) begin failures++; $display("FAIL timeout_beat got=%h exp=%h", {c_we, c_addr, c_din, c_be}, {1'b1, 29'h77, d1, 8'h0F}); end
    do_reset();
    cyc(1, 29'h78, d1, 8'h0F, 0, 0);
    for (int k = 1; k <= 14; k++) idle(0);
    cyc(1, 29'h78, d2, 8'hF0, 0, 0);
    for (int k = 16; k <= 31; k++) begin
      checks++; if (c_we !== 1'b0) begin failures++; $display("FAIL timeout_priority cycle=%0d got=%b exp=0", k, c_we); end
      idle(0);
    end
    checks++; if ({c_we, c_addr, c_din, c_be} !== {1'b1, 29'h78, d2[63:32], d1[31:0], 8'hFF}) begin failures++; $display("FAIL timeout_merged got=%h exp=%h", {c_we, c_addr, c_din, c_be}, {1'b1, 29'h78, d2[63:32], d1[31:0], 8'hFF}); end
  endtask

  task automatic test_random();
    logic we, fl, busy;
    logic [100:0] e;
    do_reset();
    model_on = 1;
    for (int n = 0; n < 500; n++) begin
      we = $urandom_range(0, 9) < 6;
      fl = n >= 400 ? (n == 400) : ($urandom_range(0, 19) == 0);
      busy = n >= 400 ? 1'b0 : ($urandom_range(0, 3) == 0);
      if (n >= 400) we = 0;
      if (c_we && !busy) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_beat unexpected got=%h exp=none", {c_addr, c_din, c_be}); end
        else begin
          e = exp_q.pop_front();
          if ({c_addr, c_din, c_be} !== e) begin failures++; $display("FAIL rand_beat got=%h exp=%h", {c_addr, c_din, c_be}, e); end
        end
      end
      cyc(we, 29'h2000 + 29'($urandom_range(0, 2)), {$urandom, $urandom}, 8'($urandom_range(1, 255)), fl, busy);
    end
    model_on = 0;
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    checks++; if ({c_pend, c_ovf} !== 2'b00) begin failures++; $display("FAIL rand_idle got=%b exp=00", {c_pend, c_ovf}); end
  endtask

  task automatic test_reset_mid();
    int nb = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 29'(i + 32), {$urandom, $urandom}, 8'hFF, 0, 1);
    checks++; if ({c_we, s_ovf} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b exp=11", {c_we, s_ovf}); end
    RESET = 1;
    idle(1);
    RESET = 0;
    checks++; if ({c_we, s_we, c_pend, s_pend} !== 4'd0) begin failures++; $display("FAIL rstmid_we got=%b exp=0000", {c_we, s_we, c_pend, s_pend}); end
    checks++; if ({s_ovf, s_drop} !== 17'd0) begin failures++; $display("FAIL rstmid_ovf got=%h exp=0", {s_ovf, s_drop}); end
    for (int j = 0; j < 20; j++) begin
      if (c_we || s_we) nb++;
      cyc(0, '0, '0, '0, j == 0, 0);
    end
    checks++; if (nb !== 0) begin failures++; $display("FAIL rstmid_beats got=%0d exp=0", nb); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_merge();
    test_latency();
    test_stall();
    test_overflow();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
